// File: rtl/ws_array_controller.sv
// Sequencer for an N x N weight-stationary systolic array.
// Loads one weight tile (bottom row first), streams a batch of skewed activation
// vectors, flags valid bottom-row sums per column, and pulses done at the end.
// Every output is a flop, loaded from a decode of the next-state values.
module ws_array_controller #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [K_WIDTH-1:0]            k_len,
  input  logic                          abort,
  output logic [1:0]                    pe_control,
  output logic                          w_rd_en,
  output logic [$clog2(ARRAY_SIZE)-1:0] w_rd_addr,
  output logic [ARRAY_SIZE-1:0]         a_row_en,
  output logic [ARRAY_SIZE-1:0]         out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int N  = ARRAY_SIZE;
  localparam int AW = $clog2(N);
  localparam int CW = K_WIDTH + $clog2(2 * N) + 1;

  localparam logic [1:0] PE_CLEAR   = 2'b00;
  localparam logic [1:0] PE_LOAD    = 2'b01;
  localparam logic [1:0] PE_COMPUTE = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMPUTE,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [K_WIDTH-1:0]   klen_q, klen_d;

  logic [1:0]           pe_control_q, pe_control_d;
  logic                 w_rd_en_q, w_rd_en_d;
  logic [AW-1:0]        w_rd_addr_q, w_rd_addr_d;
  logic [N-1:0]         a_row_en_q, a_row_en_d;
  logic [N-1:0]         out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [CW-1:0]        compute_last;

  assign compute_last = CW'(klen_q) + CW'(2 * N - 2);

  // Next-state and counter sequencing; abort overrides every transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    klen_d  = klen_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start && (k_len != '0)) begin
          state_d = S_LOAD;
          klen_d  = k_len;
        end
      end
      S_LOAD: begin
        if (cnt_q == CW'(N - 1)) begin
          state_d = S_COMPUTE;
          cnt_d   = '0;
        end
      end
      S_COMPUTE: begin
        if (cnt_q == compute_last) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  // Output decode of the next state, so the registered outputs line up with the state they describe.
  always_comb begin
    pe_control_d = PE_CLEAR;
    w_rd_en_d    = 1'b0;
    w_rd_addr_d  = '0;
    a_row_en_d   = '0;
    out_valid_d  = '0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_d)
      S_LOAD: begin
        pe_control_d = PE_LOAD;
        w_rd_en_d    = 1'b1;
        w_rd_addr_d  = AW'(N - 1) - cnt_d[AW-1:0];
        busy_d       = 1'b1;
      end
      S_COMPUTE: begin
        pe_control_d = PE_COMPUTE;
        busy_d       = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
          a_row_en_d[i]  = (cnt_d >= CW'(i)) && (cnt_d < CW'(i) + CW'(klen_d));
          out_valid_d[i] = (cnt_d >= CW'(N + i)) && (cnt_d < CW'(N + i) + CW'(klen_d));
        end
      end
      S_DONE: begin
        busy_d = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // State, counter, latched batch length and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      klen_q       <= '0;
      pe_control_q <= PE_CLEAR;
      w_rd_en_q    <= 1'b0;
      w_rd_addr_q  <= '0;
      a_row_en_q   <= '0;
      out_valid_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      klen_q       <= klen_d;
      pe_control_q <= pe_control_d;
      w_rd_en_q    <= w_rd_en_d;
      w_rd_addr_q  <= w_rd_addr_d;
      a_row_en_q   <= a_row_en_d;
      out_valid_q  <= out_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pe_control = pe_control_q;
  assign w_rd_en    = w_rd_en_q;
  assign w_rd_addr  = w_rd_addr_q;
  assign a_row_en   = a_row_en_q;
  assign out_valid  = out_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ws_array_controller.sv
// Directed bench for ws_array_controller (N=4, K_WIDTH=8) with a behavioural
// WS PE grid driven by the controller outputs, identity weights.
module tb_ws_array_controller;

  localparam int N  = 4;
  localparam int KW = 8;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [KW-1:0] k_len;
  logic          abort;
  logic [1:0]    pe_control;
  logic          w_rd_en;
  logic [1:0]    w_rd_addr;
  logic [N-1:0]  a_row_en;
  logic [N-1:0]  out_valid;
  logic          busy;
  logic          done;

  int checks = 0;
  int errors = 0;

  ws_array_controller #(.ARRAY_SIZE(N), .K_WIDTH(KW)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .k_len      (k_len),
    .abort      (abort),
    .pe_control (pe_control),
    .w_rd_en    (w_rd_en),
    .w_rd_addr  (w_rd_addr),
    .a_row_en   (a_row_en),
    .out_valid  (out_valid),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Activation element for vector t, row r.
  function automatic logic [15:0] act_val(input int t, input int r);
    return 16'(10 * t + r + 1);
  endfunction

  // Behavioural PE grid: weights shift down on 01, activations right / sums down on 10, clear on 00.
  logic [15:0] gw [N][N];
  logic [15:0] ga [N][N];
  logic [15:0] gp [N][N];
  int          rd_ptr [N];
  int          ov_cnt [N];
  logic [15:0] ain, pin;

  always @(posedge clk) begin
    for (int r = 0; r < N; r++) begin
      if (pe_control == 2'b01) rd_ptr[r] <= 0;
      else if (a_row_en[r]) rd_ptr[r] <= rd_ptr[r] + 1;
      if (pe_control == 2'b01) ov_cnt[r] <= 0;
      else if (out_valid[r]) ov_cnt[r] <= ov_cnt[r] + 1;
      for (int c = 0; c < N; c++) begin
        if (pe_control == 2'b00) begin
          gw[r][c] <= '0;
          ga[r][c] <= '0;
          gp[r][c] <= '0;
        end else if (pe_control == 2'b01) begin
          if (r == 0) gw[r][c] <= (w_rd_en && (w_rd_addr == 2'(c))) ? 16'd1 : 16'd0;
          else        gw[r][c] <= gw[r-1][c];
        end else if (pe_control == 2'b10) begin
          if (c == 0) ain = a_row_en[r] ? act_val(rd_ptr[r], r) : 16'd0;
          else        ain = ga[r][c-1];
          if (r == 0) pin = 16'd0;
          else        pin = gp[r-1][c];
          ga[r][c] <= ain;
          gp[r][c] <= pin + gw[r][c] * ain;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; k_len = '0; abort = 1'b0;
    repeat (3) step();
    checks++;
    if ({pe_control, w_rd_en, w_rd_addr, a_row_en, out_valid, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got pe=%b wen=%b addr=%0d a=%b ov=%b busy=%b done=%b want all 0",
               pe_control, w_rd_en, w_rd_addr, a_row_en, out_valid, busy, done);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({pe_control, w_rd_en, w_rd_addr, a_row_en, out_valid, busy, done} !== '0) begin
        errors++;
        $display("FAIL idle_outputs cyc %0d: got pe=%b busy=%b done=%b a=%b ov=%b want all 0",
                 i, pe_control, busy, done, a_row_en, out_valid);
      end
    end
  endtask

  // k_len=3 from cycle 0: full timing table plus grid data check.
  task automatic test_basic(input string tag);
    logic [1:0] e_pc, e_addr;
    logic       e_wen, e_busy, e_done;
    logic [3:0] e_a, e_ov;
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0; k_len = 8'hAA;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      e_pc   = (cyc <= 4) ? 2'b01 : (cyc <= 14) ? 2'b10 : 2'b00;
      e_wen  = (cyc <= 4);
      e_addr = e_wen ? 2'(4 - cyc) : 2'd0;
      for (int i = 0; i < N; i++) begin
        e_a[i]  = (cyc >= 5 + i) && (cyc <= 7 + i);
        e_ov[i] = (cyc >= 9 + i) && (cyc <= 11 + i);
      end
      e_busy = (cyc <= 15);
      e_done = (cyc == 15);
      checks++;
      if (pe_control !== e_pc) begin errors++;
        $display("FAIL %s pe_control cyc %0d: got %b want %b", tag, cyc, pe_control, e_pc); end
      checks++;
      if (w_rd_en !== e_wen) begin errors++;
        $display("FAIL %s w_rd_en cyc %0d: got %b want %b", tag, cyc, w_rd_en, e_wen); end
      checks++;
      if (w_rd_addr !== e_addr) begin errors++;
        $display("FAIL %s w_rd_addr cyc %0d: got %0d want %0d", tag, cyc, w_rd_addr, e_addr); end
      checks++;
      if (a_row_en !== e_a) begin errors++;
        $display("FAIL %s a_row_en cyc %0d: got %b want %b", tag, cyc, a_row_en, e_a); end
      checks++;
      if (out_valid !== e_ov) begin errors++;
        $display("FAIL %s out_valid cyc %0d: got %b want %b", tag, cyc, out_valid, e_ov); end
      checks++;
      if (busy !== e_busy) begin errors++;
        $display("FAIL %s busy cyc %0d: got %b want %b", tag, cyc, busy, e_busy); end
      checks++;
      if (done !== e_done) begin errors++;
        $display("FAIL %s done cyc %0d: got %b want %b", tag, cyc, done, e_done); end
      for (int c = 0; c < N; c++) begin
        if (out_valid[c]) begin
          checks++;
          if (ov_cnt[c] > 2 || gp[N-1][c] !== act_val(ov_cnt[c], c)) begin errors++;
            $display("FAIL %s grid_sum col %0d cyc %0d: got %0d want %0d", tag, c, cyc,
                     gp[N-1][c], act_val(ov_cnt[c], c)); end
        end
      end
      if (cyc < 17) step();
    end
  endtask

  task automatic test_kzero();
    start = 1'b1; k_len = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (busy !== 1'b0 || pe_control !== 2'b00 || w_rd_en !== 1'b0) begin errors++;
        $display("FAIL kzero cyc %0d: got busy=%b pe=%b wen=%b want 0/00/0", i, busy, pe_control, w_rd_en); end
      step();
    end
  endtask

  task automatic test_start_during_compute();
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 17; cyc++) begin
      checks++;
      if (done !== (cyc == 15) || busy !== (cyc <= 15)) begin errors++;
        $display("FAIL start_in_compute cyc %0d: got done=%b busy=%b want %b %b",
                 cyc, done, busy, (cyc == 15), (cyc <= 15)); end
      if (cyc == 7) begin start = 1'b1; k_len = 8'd5; end
      else begin start = 1'b0; end
      if (cyc < 17) step();
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_abort();
    start = 1'b1; k_len = 8'd3;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 7; cyc++) step();
    checks++;
    if (pe_control !== 2'b10) begin errors++;
      $display("FAIL abort_precond: got pe=%b want 10", pe_control); end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({pe_control, w_rd_en, w_rd_addr, a_row_en, out_valid, busy, done} !== '0) begin errors++;
      $display("FAIL abort_outputs: got pe=%b a=%b ov=%b busy=%b done=%b want all 0",
               pe_control, a_row_en, out_valid, busy, done); end
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin errors++;
        $display("FAIL abort_no_done cyc %0d: got done=%b busy=%b want 0 0", i, done, busy); end
    end
    // Abort in IDLE is ignored: the start in the same cycle is taken.
    start = 1'b1; k_len = 8'd2; abort = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || pe_control !== 2'b01) begin errors++;
      $display("FAIL abort_in_idle: got busy=%b pe=%b want 1 01", busy, pe_control); end
    step();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || pe_control !== 2'b00) begin errors++;
      $display("FAIL abort_in_load: got busy=%b pe=%b want 0 00", busy, pe_control); end
    step();
  endtask

  task automatic test_back_to_back();
    start = 1'b1; k_len = 8'd1;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 28; cyc++) begin
      checks++;
      if (done !== (cyc == 13 || cyc == 27) || busy !== !(cyc == 14 || cyc == 28)) begin errors++;
        $display("FAIL back_to_back cyc %0d: got done=%b busy=%b", cyc, done, busy); end
      if (cyc == 14 || cyc == 15) begin
        checks++;
        if (pe_control !== ((cyc == 14) ? 2'b00 : 2'b01)) begin errors++;
          $display("FAIL back_to_back pe cyc %0d: got %b", cyc, pe_control); end
      end
      for (int c = 0; c < N; c++) begin
        if (out_valid[c]) begin
          checks++;
          if (ov_cnt[c] != 0 || gp[N-1][c] !== act_val(0, c)) begin errors++;
            $display("FAIL back_to_back grid col %0d cyc %0d: got %0d want %0d", c, cyc,
                     gp[N-1][c], act_val(0, c)); end
        end
      end
      start = (cyc == 14);
      k_len = 8'd1;
      if (cyc < 28) step();
    end
    start = 1'b0;
    step();
  endtask

  task automatic test_max_batch();
    int busy_cnt, comp_cnt, done_cnt, done_cyc;
    busy_cnt = 0; comp_cnt = 0; done_cnt = 0; done_cyc = -1;
    start = 1'b1; k_len = 8'd255;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc <= 270; cyc++) begin
      if (busy) busy_cnt++;
      if (pe_control == 2'b10) comp_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      step();
    end
    checks++;
    if (comp_cnt != 262) begin errors++;
      $display("FAIL max_compute_len: got %0d want 262", comp_cnt); end
    checks++;
    if (done_cnt != 1 || done_cyc != 267) begin errors++;
      $display("FAIL max_done: got %0d pulses at cyc %0d want 1 at 267", done_cnt, done_cyc); end
    checks++;
    if (busy_cnt != 267) begin errors++;
      $display("FAIL max_busy_span: got %0d want 267", busy_cnt); end
    // Rerun with a reset pulse at cycle 100.
    start = 1'b1; k_len = 8'd255;
    step();
    start = 1'b0;
    for (int cyc = 1; cyc < 100; cyc++) step();
    checks++;
    if (busy !== 1'b1 || pe_control !== 2'b10) begin errors++;
      $display("FAIL rerun_precond: got busy=%b pe=%b want 1 10", busy, pe_control); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({pe_control, w_rd_en, w_rd_addr, a_row_en, out_valid, busy, done} !== '0) begin errors++;
      $display("FAIL async_reset: got pe=%b a=%b ov=%b busy=%b done=%b want all 0",
               pe_control, a_row_en, out_valid, busy, done); end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || pe_control !== 2'b00) begin errors++;
        $display("FAIL post_reset_idle cyc %0d: got busy=%b done=%b pe=%b", i, busy, done, pe_control); end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic("basic");
    test_kzero();
    test_start_during_compute();
    test_abort();
    test_basic("after_abort");
    step();
    test_back_to_back();
    test_max_batch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
